sad_search_controller: RTL and testbench

- Sequences the 4x4 SAD datapath (frame/window shift registers plus four SAD_4x8bit lanes) for a full-search motion-estimation pass over a FRAME_W x FRAME_H byte-per-pixel frame.
- Issues memory reads and drives window_shift/frame_shift.
- Samples the combinational SAD result and tracks the minimum SAD and its (x,y) position.
- Sits between the core's SAD-instruction issue logic and the SAD memory read port.

---
 rtl/sad_pkg.sv | 17 +
 rtl/sad_min_tracker.sv | 39 +++
 rtl/sad_search_controller.sv | 158 +++++++++++++++
 tb/tb_sad_search_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD full-search controller.
// Optional early exit on an exact match is enabled by SAD_EARLY_EXIT_EN.
package sad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_WIN,
      SCAN,
      FINISH
   } state_t;

   localparam int          WIN_ROWS     = 4;
   localparam int          PIX_PER_WORD = 4;
   localparam logic [31:0] SAD_INIT     = 32'hFFFF_FFFF;
   localparam int          SAD_SIG_W    = 13;

endpackage

// File: rtl/sad_min_tracker.sv
// Running minimum of the sampled SAD with its (x,y) position.
// Strict less-than keeps the earliest position on ties.
module sad_min_tracker
   import sad_pkg::*;
#(
   parameter int COORD_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               valid,
   input  logic [31:0]        sad,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [31:0]        best_sad,
   output logic [COORD_W-1:0] best_x,
   output logic [COORD_W-1:0] best_y
);

   logic [31:0] sad_sig;
   logic        unused_hi;

   // A 4x4 byte SAD never exceeds 4080, so only the low bits carry meaning.
   assign sad_sig   = {{(32-SAD_SIG_W){1'b0}}, sad[SAD_SIG_W-1:0]};
   assign unused_hi = ^sad[31:SAD_SIG_W];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         best_sad <= SAD_INIT;
         best_x   <= '0;
         best_y   <= '0;
      end else if (valid && (sad_sig < best_sad)) begin
         best_sad <= sad_sig;
         best_x   <= x;
         best_y   <= y;
      end
   end

endmodule

// File: rtl/sad_search_controller.sv
// Full-search motion-estimation sequencer for the 4x4 SAD datapath.
// Define SAD_EARLY_EXIT_EN to stop the scan on the first exact match.
module sad_search_controller
   import sad_pkg::*;
#(
   parameter int FRAME_W = 64,
   parameter int FRAME_H = 64,
   parameter int COORD_W = 16,
   parameter int ADDR_W  = 32
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  frame_base,
   input  logic [ADDR_W-1:0]  window_base,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [31:0]        sad_value,
   output logic               window_shift,
   output logic               frame_shift,
   output logic               busy,
   output logic               done,
   output logic [COORD_W-1:0] best_x,
   output logic [COORD_W-1:0] best_y,
   output logic [31:0]        best_sad
);

   localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(FRAME_W - 4);
   localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(FRAME_H - 1);
   localparam logic [COORD_W-1:0] Y_FILL   = COORD_W'(WIN_ROWS - 1);
   localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(FRAME_W);
   localparam logic [ADDR_W-1:0]  WIN_STEP = ADDR_W'(PIX_PER_WORD);
   localparam logic [1:0]         ROW_LAST = 2'(WIN_ROWS - 1);

   state_t             state;
   logic [ADDR_W-1:0]  frame_q;
   logic [ADDR_W-1:0]  win_q;
   logic [1:0]         row;
   logic               rd_en_q;
   logic               rd_frame;
   logic [COORD_W-1:0] rd_x;
   logic [COORD_W-1:0] rd_y;
   logic [COORD_W-1:0] dx;
   logic [COORD_W-1:0] dy;
   logic               sad_valid;
   logic               clear;

   // First three rows of each column only flush the previous column.
   assign sad_valid = frame_shift && (dy >= Y_FILL);
   assign clear     = (state == IDLE) && start;

`ifdef SAD_EARLY_EXIT_EN
   logic hit;
   assign hit       = sad_valid && (sad_value[SAD_SIG_W-1:0] == '0);
   assign mem_rd_en = rd_en_q && !hit;
`else
   assign mem_rd_en = rd_en_q;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         frame_q      <= '0;
         win_q        <= '0;
         row          <= '0;
         rd_en_q      <= 1'b0;
         rd_frame     <= 1'b0;
         rd_x         <= '0;
         rd_y         <= '0;
         dx           <= '0;
         dy           <= '0;
         mem_addr     <= '0;
         window_shift <= 1'b0;
         frame_shift  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         window_shift <= mem_rd_en && !rd_frame;
         frame_shift  <= mem_rd_en && rd_frame;
         dx           <= rd_x;
         dy           <= rd_y;
         done         <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  frame_q  <= frame_base;
                  win_q    <= window_base;
                  busy     <= 1'b1;
                  rd_en_q  <= 1'b1;
                  mem_addr <= window_base;
                  row      <= '0;
                  rd_frame <= 1'b0;
                  rd_x     <= '0;
                  rd_y     <= '0;
                  state    <= LOAD_WIN;
               end
            end
            LOAD_WIN: begin
               if (row == ROW_LAST) begin
                  rd_frame <= 1'b1;
                  mem_addr <= frame_q;
                  state    <= SCAN;
               end else begin
                  row      <= row + 2'd1;
                  mem_addr <= win_q + ADDR_W'(row + 2'd1) * WIN_STEP;
               end
            end
            SCAN: begin
`ifdef SAD_EARLY_EXIT_EN
               if (hit) begin
                  rd_en_q <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= FINISH;
               end else
`endif
               if (rd_en_q) begin
                  if (rd_y == Y_LAST) begin
                     if (rd_x == X_LAST) begin
                        rd_en_q <= 1'b0;
                     end else begin
                        rd_x     <= rd_x + 1'b1;
                        rd_y     <= '0;
                        mem_addr <= frame_q + ADDR_W'(rd_x) + ADDR_W'(1);
                     end
                  end else begin
                     rd_y     <= rd_y + 1'b1;
                     mem_addr <= mem_addr + ROW_STEP;
                  end
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FINISH;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
         endcase
      end
   end

   sad_min_tracker #(
      .COORD_W (COORD_W)
   ) u_tracker (
      .clk      (Clk),
      .reset    (Reset),
      .clear    (clear),
      .valid    (sad_valid),
      .sad      (sad_value),
      .x        (dx),
      .y        (dy - Y_FILL),
      .best_sad (best_sad),
      .best_x   (best_x),
      .best_y   (best_y)
   );

endmodule

// File: tb/tb_sad_search_controller.sv
// Directed bench: memory + SAD datapath model around the controller.
// Build with SAD_EARLY_EXIT_EN to exercise the early-exit variant.
module tb_sad_search_controller;

   localparam int W = 8;
   localparam int H = 8;
   localparam logic [31:0] WB = 32'h0000_0040;
   localparam logic [31:0] FB = 32'h0000_0100;

`ifdef SAD_EARLY_EXIT_EN
   localparam int T1_READS = 27;
   localparam int T1_DONE  = 29;
   localparam int T1_BUSY  = 28;
   localparam int T1_FS    = 23;
`else
   localparam int T1_READS = 44;
   localparam int T1_DONE  = 46;
   localparam int T1_BUSY  = 45;
   localparam int T1_FS    = 40;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [31:0] sad_value;
   logic        window_shift;
   logic        frame_shift;
   logic        busy;
   logic        done;
   logic [15:0] best_x;
   logic [15:0] best_y;
   logic [31:0] best_sad;

   logic [7:0]  mem [0:1023];
   logic [31:0] rd_data = '0;
   logic [31:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
   logic [31:0] f1 = '0, f2 = '0, f3 = '0;

   int total = 0;
   int bad   = 0;
   int n_reads, first_rd, last_rd, done_cyc, n_done, n_busy;
   int n_ws, n_fs, n_both, n_addr_err;
   logic        snap_busy, snap_rd, snap_done;
   logic [31:0] snap_sad;

   sad_search_controller #(
      .FRAME_W (W),
      .FRAME_H (H),
      .COORD_W (16),
      .ADDR_W  (32)
   ) dut (
      .Clk          (clk),
      .Reset        (rst),
      .start        (start),
      .frame_base   (FB),
      .window_base  (WB),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .sad_value    (sad_value),
      .window_shift (window_shift),
      .frame_shift  (frame_shift),
      .busy         (busy),
      .done         (done),
      .best_x       (best_x),
      .best_y       (best_y),
      .best_sad     (best_sad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      int b;
      b = int'(a[9:0]);
      return {mem[(b+3) % 1024], mem[(b+2) % 1024],
              mem[(b+1) % 1024], mem[b]};
   endfunction

   function automatic int sadw(input logic [31:0] a, input logic [31:0] b);
      int s;
      int d;
      s = 0;
      for (int k = 0; k < 4; k++) begin
         d = int'(a[8*k +: 8]) - int'(b[8*k +: 8]);
         s += (d < 0) ? -d : d;
      end
      return s;
   endfunction

   function automatic logic [31:0] exp_addr(input int i);
      int j;
      if (i < 4) return WB + 32'(4 * i);
      j = i - 4;
      return FB + 32'((j % H) * W + (j / H));
   endfunction

   // 1-cycle read latency, and shift registers fed by the read port.
   always @(posedge clk) begin
      if (mem_rd_en) rd_data <= word_at(mem_addr);
      if (window_shift) begin
         w0 <= w1; w1 <= w2; w2 <= w3; w3 <= rd_data;
      end
      if (frame_shift) begin
         f1 <= f2; f2 <= f3; f3 <= rd_data;
      end
   end

   always_comb begin
      sad_value = 32'(sadw(w0, f1) + sadw(w1, f2) + sadw(w2, f3) + sadw(w3, rd_data));
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_window(input int base_val, input int step);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            mem[int'(WB) + 4*r + c] = 8'(base_val + (r*4 + c) * step);
   endtask

   task automatic fill_frame(input int v);
      for (int i = 0; i < W*H; i++) mem[int'(FB) + i] = 8'(v);
   endtask

   task automatic load_plant(input int px, input int py);
      set_window(0, 3);
      for (int i = 0; i < W*H; i++)
         mem[int'(FB) + i] = 8'($urandom_range(255, 100));
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            mem[int'(FB) + (py + r)*W + px + c] = mem[int'(WB) + 4*r + c];
   endtask

   task automatic load_two_min();
      set_window(0, 0);
      fill_frame(200);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            mem[int'(FB) + r*W + 1 + c]     = 8'd0;
            mem[int'(FB) + (4 + r)*W + c]   = 8'd0;
         end
      mem[int'(FB) + 0*W + 1] = 8'd5;
      mem[int'(FB) + 4*W + 0] = 8'd5;
   endtask

   // Start at edge E0, then observe cycles 1..60 on falling edges.
   task automatic run(input int pa, input int pb, input int pc, input int rst_at);
      n_reads = 0; first_rd = 0; last_rd = 0; done_cyc = 0; n_done = 0;
      n_busy = 0; n_ws = 0; n_fs = 0; n_both = 0; n_addr_err = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (mem_rd_en) begin
            if (mem_addr !== exp_addr(n_reads)) n_addr_err++;
            if (n_reads == 0) first_rd = c;
            last_rd = c;
            n_reads++;
         end
         if (done) begin
            n_done++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (busy) n_busy++;
         if (window_shift) n_ws++;
         if (frame_shift) n_fs++;
         if (window_shift && frame_shift) n_both++;
         if (c == rst_at + 1) begin
            snap_busy = busy;
            snap_rd   = mem_rd_en;
            snap_sad  = best_sad;
            snap_done = done;
            rst = 1'b0;
         end
         start = (c == pa) || (c == pb) || (c == pc);
         if (c == rst_at) rst = 1'b1;
      end
      start = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_best_sad", best_sad, 32'hFFFF_FFFF);
      chk("rst_best_x", best_x, 0);
      chk("rst_best_y", best_y, 0);
      chk("rst_wshift", window_shift, 0);
      chk("rst_fshift", frame_shift, 0);
      rst = 1'b0;

      // Exact match planted at (2,3)
      load_plant(2, 3);
      run(0, 0, 0, 0);
      chk("t1_reads", n_reads, T1_READS);
      chk("t1_first_rd", first_rd, 1);
      chk("t1_last_rd", last_rd, T1_READS);
      chk("t1_done_cyc", done_cyc, T1_DONE);
      chk("t1_n_done", n_done, 1);
      chk("t1_busy_cycles", n_busy, T1_BUSY);
      chk("t1_wshift", n_ws, 4);
      chk("t1_fshift", n_fs, T1_FS);
      chk("t1_both_shift", n_both, 0);
      chk("t1_addr_err", n_addr_err, 0);
      chk("t1_best_x", best_x, 2);
      chk("t1_best_y", best_y, 3);
      chk("t1_best_sad", best_sad, 0);
      repeat (5) @(negedge clk);
      chk("t1_hold_x", best_x, 2);
      chk("t1_hold_sad", best_sad, 0);

      // Equal minima: (0,4) precedes (1,0) in column-major order
      load_two_min();
      run(0, 0, 0, 0);
      chk("t2_best_x", best_x, 0);
      chk("t2_best_y", best_y, 4);
      chk("t2_best_sad", best_sad, 5);
      chk("t2_n_done", n_done, 1);

      // Worst-case SAD everywhere
      set_window(0, 0);
      fill_frame(255);
      run(0, 0, 0, 0);
      chk("t3_best_sad", best_sad, 4080);
      chk("t3_best_x", best_x, 0);
      chk("t3_best_y", best_y, 0);

      // Reset mid-search, then a clean restart
      load_plant(2, 3);
      run(0, 0, 0, 20);
      chk("t4_busy", snap_busy, 0);
      chk("t4_rd_en", snap_rd, 0);
      chk("t4_best_sad", snap_sad, 32'hFFFF_FFFF);
      chk("t4_done_now", snap_done, 0);
      chk("t4_n_done", n_done, 0);
      run(0, 0, 0, 0);
      chk("t4b_done_cyc", done_cyc, T1_DONE);
      chk("t4b_best_x", best_x, 2);
      chk("t4b_best_y", best_y, 3);
      chk("t4b_best_sad", best_sad, 0);

      // start while busy and in the FINISH cycle is ignored
      set_window(0, 0);
      fill_frame(255);
      run(5, 30, 46, 0);
      chk("t5_reads", n_reads, 44);
      chk("t5_n_done", n_done, 1);
      chk("t5_done_cyc", done_cyc, 46);
      chk("t5_busy_cycles", n_busy, 45);
      chk("t5_last_rd", last_rd, 44);

`ifdef SAD_EARLY_EXIT_EN
      // Exact match at the very first position
      load_plant(0, 0);
      run(0, 0, 0, 0);
      chk("t6_reads", n_reads, 8);
      chk("t6_done_cyc", done_cyc, 10);
      chk("t6_best_x", best_x, 0);
      chk("t6_best_y", best_y, 0);
      chk("t6_best_sad", best_sad, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
